// File: rtl/iomem_initiator.sv
// Command/response front end that turns single commands into iomem bus cycles,
// aborting a bus request that is not completed within TIMEOUT_CYCLES.
module iomem_initiator #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic        iomem_valid,
  input  logic        iomem_ready,
  output logic [3:0]  iomem_wstrb,
  output logic [31:0] iomem_addr,
  output logic [31:0] iomem_wdata,
  input  logic [31:0] iomem_rdata,
  output logic        busy,
  output logic [15:0] txn_count,
  output logic [7:0]  err_count
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] tmo_cnt;
  logic       cmd_fire;
  logic       null_write;
  logic       bus_done;
  logic       tmo_hit;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign cmd_fire    = cmd_valid && (state == IDLE);
  assign null_write  = cmd_write && (cmd_wstrb == 4'h0);
  assign bus_done    = (state == REQ) && iomem_ready;
  // A completion on the same edge as the last allowed cycle counts as success.
  assign tmo_hit     = (state == REQ) && !iomem_ready && (tmo_cnt == TMO_LAST);

  assign cmd_ready   = (state == IDLE) && !reset;
  assign rsp_valid   = (state == RSP);
  assign iomem_valid = (state == REQ);
  assign busy        = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_valid) state_nxt = null_write ? RSP : REQ;
      REQ:     if (bus_done || tmo_hit) state_nxt = RSP;
      RSP:     if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      iomem_addr  <= '0;
      iomem_wdata <= '0;
      iomem_wstrb <= '0;
      rsp_rdata   <= '0;
      rsp_error   <= 1'b0;
      txn_count   <= '0;
      err_count   <= '0;
      tmo_cnt     <= '0;
    end else begin
      if (cmd_fire) begin
        iomem_addr  <= cmd_addr;
        iomem_wdata <= cmd_wdata;
        iomem_wstrb <= cmd_write ? cmd_wstrb : 4'h0;
        tmo_cnt     <= '0;
        // A write with no byte lanes completes without touching the bus.
        if (null_write) begin
          rsp_rdata <= '0;
          rsp_error <= 1'b0;
          txn_count <= txn_count + 16'd1;
        end
      end else if (state == REQ) begin
        tmo_cnt <= tmo_cnt + 8'd1;
      end

      if (bus_done) begin
        rsp_rdata <= (iomem_wstrb == 4'h0) ? iomem_rdata : 32'h0;
        rsp_error <= 1'b0;
        txn_count <= txn_count + 16'd1;
      end else if (tmo_hit) begin
        rsp_rdata <= '0;
        rsp_error <= 1'b1;
        txn_count <= txn_count + 16'd1;
        err_count <= sat_inc8(err_count);
      end
    end
  end

endmodule

// File: tb/tb_iomem_initiator.sv
// Randomized bench for iomem_initiator: each transaction is predicted from the
// command, the responder delay and the timeout limit, then compared cycle by cycle.
module tb_iomem_initiator;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_error;
  logic [31:0] rsp_rdata;
  logic        iomem_valid, iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr, iomem_wdata, iomem_rdata;
  logic        busy;
  logic [15:0] txn_count;
  logic [7:0]  err_count;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          acc_cyc = 0;
  logic [15:0] exp_txn;
  logic [7:0]  exp_err;

  iomem_initiator #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error), .iomem_valid(iomem_valid), .iomem_ready(iomem_ready),
    .iomem_wstrb(iomem_wstrb), .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata),
    .iomem_rdata(iomem_rdata), .busy(busy), .txn_count(txn_count), .err_count(err_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Caller is at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  // rsp_wait < 0 means rsp_ready is already high when the response appears.
  task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input int delay, input logic [31:0] bdata,
                         input int rsp_wait);
    logic        bus;
    int          cyc_exp;
    int          n;
    logic [31:0] exp_rd;
    logic        exp_er;
    logic [3:0]  exp_strb;
    bus      = !(wr && strb == 4'h0);
    exp_strb = wr ? strb : 4'h0;
    if (!bus) begin
      cyc_exp = 0; exp_rd = 32'h0; exp_er = 1'b0;
    end else if (delay < T) begin
      cyc_exp = delay + 1; exp_rd = wr ? 32'h0 : bdata; exp_er = 1'b0;
    end else begin
      cyc_exp = T; exp_rd = 32'h0; exp_er = 1'b1;
    end

    chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    rsp_ready = (rsp_wait < 0);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_wstrb = strb;
    @(negedge clk);
    acc_cyc = cyc;
    // Garbage on the command port while busy must be ignored.
    cmd_valid = 1'($urandom); cmd_write = 1'($urandom);
    cmd_addr = $urandom; cmd_wdata = $urandom; cmd_wstrb = 4'($urandom);
    chk("busy_after_accept", 32'(busy), 32'd1);
    chk("cmd_ready_busy", 32'(cmd_ready), 32'd0);

    n = 0;
    while (iomem_valid && n < 20) begin
      chk("iomem_addr", iomem_addr, addr);
      chk("iomem_wdata", iomem_wdata, wdata);
      chk("iomem_wstrb", 32'(iomem_wstrb), 32'(exp_strb));
      chk("rsp_valid_in_req", 32'(rsp_valid), 32'd0);
      iomem_ready = (n == delay);
      iomem_rdata = (n == delay) ? bdata : $urandom;
      n++;
      @(negedge clk);
    end
    iomem_ready = 1'b0;
    chk("valid_cycles", 32'(n), 32'(cyc_exp));

    exp_txn = exp_txn + 16'd1;
    if (exp_er && exp_err != 8'hFF) exp_err = exp_err + 8'd1;

    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("iomem_valid_in_rsp", 32'(iomem_valid), 32'd0);
    chk("rsp_rdata", rsp_rdata, exp_rd);
    chk("rsp_error", 32'(rsp_error), 32'(exp_er));
    chk("txn_count", 32'(txn_count), 32'(exp_txn));
    chk("err_count", 32'(err_count), 32'(exp_err));

    for (int i = 0; i < rsp_wait; i++) begin
      iomem_ready = 1'($urandom);
      iomem_rdata = $urandom;
      @(negedge clk);
      chk("rsp_hold_valid", 32'(rsp_valid), 32'd1);
      chk("rsp_hold_rdata", rsp_rdata, exp_rd);
      chk("rsp_hold_error", 32'(rsp_error), 32'(exp_er));
      chk("rsp_hold_txn", 32'(txn_count), 32'(exp_txn));
      chk("rsp_hold_err", 32'(err_count), 32'(exp_err));
    end
    iomem_ready = 1'b0;
    rsp_ready   = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    chk("rsp_done", 32'(rsp_valid), 32'd0);
    chk("cmd_ready_after_rsp", 32'(cmd_ready), 32'd1);
    chk("busy_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    int first_acc;
    logic [31:0] a, d, bd;
    logic        w;
    logic [3:0]  s;

    reset = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rsp_ready = 1'b0; iomem_ready = 1'b0; iomem_rdata = '0;
    exp_txn = '0; exp_err = '0;
    #1;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_iomem_valid", 32'(iomem_valid), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_txn", 32'(txn_count), 32'd0);
    chk("rst_err", 32'(err_count), 32'd0);
    chk("rst_addr", iomem_addr, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

    run_txn(1'b1, 32'h0300_0000, 32'h0000_A55A, 4'h3, 2, 32'hDEAD_BEEF, 1);
    run_txn(1'b0, 32'h0300_0000, 32'h0, 4'hF, 1, 32'h1234_5678, 0);
    run_txn(1'b0, 32'h0300_0004, 32'h0, 4'h0, 50, 32'h0, 0);
    run_txn(1'b1, 32'h0300_0008, 32'hCAFE_F00D, 4'h0, 0, 32'h0, 0);
    run_txn(1'b0, 32'h0300_000C, 32'h0, 4'h0, T - 1, 32'hA5A5_0001, 2);

    run_txn(1'b0, 32'h0000_0010, 32'h0, 4'h0, 0, 32'h1111_2222, -1);
    first_acc = acc_cyc;
    run_txn(1'b0, 32'h0000_0014, 32'h0, 4'h0, 0, 32'h3333_4444, -1);
    chk("b2b_spacing", 32'(acc_cyc - first_acc), 32'd3);

    for (int k = 0; k < 40; k++) begin
      w  = 1'($urandom);
      a  = $urandom; d = $urandom; bd = $urandom;
      s  = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
      run_txn(w, a, d, s, $urandom_range(0, 6), bd, $urandom_range(0, 3) - 1);
    end

    // Reset in the middle of a bus request.
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0300_0020; cmd_wstrb = 4'h0;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("pre_rst_iomem_valid", 32'(iomem_valid), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_iomem_valid", 32'(iomem_valid), 32'd0);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("mid_rst_txn", 32'(txn_count), 32'd0);
    chk("mid_rst_err", 32'(err_count), 32'd0);
    chk("mid_rst_addr", iomem_addr, 32'd0);
    chk("mid_rst_rdata", rsp_rdata, 32'd0);
    exp_txn = '0; exp_err = '0;
    iomem_ready = 1'b1; iomem_rdata = 32'h5555_AAAA;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    reset = 1'b0;
    @(negedge clk);
    iomem_ready = 1'b0;
    chk("rst_release_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_release_rsp", 32'(rsp_valid), 32'd0);
    chk("rst_release_txn", 32'(txn_count), 32'd0);

    // Drive enough timeouts to push err_count into saturation.
    for (int k = 0; k < 258; k++)
      run_txn(1'b0, 32'h0400_0000 + 32'(k), 32'h0, 4'h0, 9, 32'h0, -1);
    chk("err_saturated", 32'(err_count), 32'hFF);

    for (int k = 0; k < 10; k++)
      run_txn(1'($urandom), $urandom, $urandom, 4'($urandom), $urandom_range(0, 6),
              $urandom, $urandom_range(0, 2) - 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/iomem_initiator.md
IOMEM_INITIATOR -- requirements
Module: iomem_initiator

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, max REQ-state cycles waiting for iomem_ready before abort; legal range 1..255.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 cmd_valid  input  1  command offered.
REQ-005 cmd_ready  output  1  command accepted when cmd_valid && cmd_ready at a clk edge.
REQ-006 cmd_write  input  1  1 = write, 0 = read.
REQ-007 cmd_addr  input  32  target byte address.
REQ-008 cmd_wdata  input  32  write data.
REQ-009 cmd_wstrb  input  4  byte-lane enables for writes.
REQ-010 rsp_valid  output  1  response available.
REQ-011 rsp_ready  input  1  response consumed when rsp_valid && rsp_ready at a clk edge.
REQ-012 rsp_rdata  output  32  read data; 0 for writes and errors.
REQ-013 rsp_error  output  1  1 = transaction timed out.
REQ-014 iomem_valid  output  1  bus request.
REQ-015 iomem_ready  input  1  responder completion pulse.
REQ-016 iomem_wstrb  output  4  bus byte enables; 0 = read.
REQ-017 iomem_addr  output  32  bus address.
REQ-018 iomem_wdata  output  32  bus write data.
REQ-019 iomem_rdata  input  32  bus read data, valid with iomem_ready.
REQ-020 busy  output  1  high in any state other than IDLE.
REQ-021 txn_count  output  16  completed transactions, wraps 16'hFFFF -> 0.
REQ-022 err_count  output  8  timed-out transactions, saturates at 8'hFF.

Function
REQ-023 FSM states IDLE, REQ, RSP; cmd_ready = (state == IDLE); rsp_valid = (state == RSP); iomem_valid = (state == REQ).
REQ-024 IDLE: on cmd handshake, register cmd_addr, cmd_wdata, and iomem_wstrb = cmd_write ? cmd_wstrb : 4'h0; enter REQ next cycle (iomem_valid high one cycle after acceptance).
REQ-025 Write with cmd_wstrb == 0: no bus cycle; go directly IDLE -> RSP with rsp_error=0, rsp_rdata=0; txn_count increments.
REQ-026 REQ: iomem_addr/wdata/wstrb held stable; timeout counter clears on REQ entry and increments every REQ cycle.
REQ-027 REQ, iomem_ready high at an edge: capture rsp_rdata = read ? iomem_rdata : 0, rsp_error=0, txn_count+1, enter RSP; iomem_valid low the following cycle.
REQ-028 REQ, counter reaches TIMEOUT_CYCLES with iomem_ready low: rsp_error=1, rsp_rdata=0, txn_count+1, err_count+1 (saturating), enter RSP.
REQ-029 iomem_ready on the same edge as timeout: success wins, no error.
REQ-030 iomem_ready while not in REQ: ignored, no state or counter change.
REQ-031 RSP: rsp_rdata/rsp_error stable until rsp_ready; on handshake return to IDLE; next command accepted no earlier than the following cycle (min 3 cycles per bus transaction).
REQ-032 rsp_ready held high in advance: handshake completes in the first RSP cycle.
REQ-033 Command inputs ignored outside IDLE.

Reset
REQ-034 reset asserted: immediately (no clock) state=IDLE, iomem_valid=0, rsp_valid=0, cmd_ready=0 while reset high, busy=0, iomem_addr/wdata/wstrb=0, rsp_rdata=0, rsp_error=0, txn_count=0, err_count=0, timeout counter=0.
REQ-035 Reset mid-REQ aborts the bus cycle with no response issued; first edge after release: cmd_ready=1.

Verification
REQ-036 Write addr=32'h0300_0000, wdata=32'h0000_A55A, wstrb=4'h3, responder ready after 2 cycles -> iomem_valid high 3 cycles with iomem_wstrb=4'h3, rsp_valid 1 cycle after ready, rsp_error=0, rsp_rdata=0, txn_count=1.
REQ-037 Read addr=32'h0300_0000, responder returns 32'h1234_5678 with ready -> iomem_wstrb=0, rsp_rdata=32'h1234_5678, rsp_error=0.
REQ-038 Read with TIMEOUT_CYCLES=4, iomem_ready never asserted -> iomem_valid high exactly 4 cycles, rsp_error=1, rsp_rdata=0, err_count=1.
REQ-039 Two commands back-to-back, rsp_ready tied high, ready in first REQ cycle -> second cmd_ready 3 cycles after first acceptance, txn_count=2, iomem_valid low at least 1 cycle between requests.
REQ-040 Assert reset during REQ, then drive iomem_ready -> iomem_valid drops asynchronously, no rsp_valid, counters=0.
REQ-041 Write with cmd_wstrb=0 -> iomem_valid never asserted, rsp_valid next cycle, rsp_error=0.
